// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer with branch/jump/register redirects,
// single-level exception entry and eret return.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_valid,
    input  logic [31:0] j_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [2:0]  pc_sel,
    output logic [31:0] epc,
    output logic        exl,
    output logic        flush
);
    typedef enum logic {RUN, EXC} state_t;
    typedef enum logic [2:0] {
        SEL_PC4  = 3'b000,
        SEL_BR   = 3'b001,
        SEL_J    = 3'b010,
        SEL_JR   = 3'b011,
        SEL_EPC  = 3'b100,
        SEL_HDLR = 3'b101,
        SEL_HOLD = 3'b111
    } sel_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, epc_q, epc_d, exc_ret;
    sel_t        sel;
    logic        take_exc, take_eret;
    assign take_exc  = !reset && exc_req && state_q == RUN;
    assign take_eret = !reset && eret && state_q == EXC;
    // A delay-slot fault restarts at the branch preceding it.
    assign exc_ret   = exc_bd ? exc_pc - 32'd4 : exc_pc;
    always_comb begin
        sel = take_exc  ? SEL_HDLR :
              take_eret ? SEL_EPC  :
              reset     ? SEL_PC4  :
              stall     ? SEL_HOLD :
              jr_valid  ? SEL_JR   :
              j_valid   ? SEL_J    :
              br_taken  ? SEL_BR   : SEL_PC4;
        pc_d = pc_q + 32'd4;
        case (sel)
            SEL_HDLR: pc_d = HANDLER_PC;
            SEL_EPC:  pc_d = epc_q;
            SEL_HOLD: pc_d = pc_q;
            SEL_JR:   pc_d = jr_target;
            SEL_J:    pc_d = j_target;
            SEL_BR:   pc_d = br_target;
            default:  pc_d = pc_q + 32'd4;
        endcase
        epc_d   = take_exc ? {exc_ret[31:2], 2'b00} : epc_q;
        state_d = take_exc ? EXC : take_eret ? RUN : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            state_q <= state_d;
        end
    end
    assign pc     = pc_q;
    assign epc    = epc_q;
    assign exl    = state_q == EXC;
    assign pc_sel = sel;
    assign flush  = take_exc || take_eret;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: directed vectors with a queued scoreboard; a negedge monitor
// checks combinational outputs in the issue cycle and registered state one cycle later.
module tb_pc_seq_ctrl;
    logic        clk = 0, reset, stall, br_taken, j_valid, jr_valid, exc_req, exc_bd, eret;
    logic [31:0] br_target, j_target, jr_target, exc_pc;
    logic [31:0] pc, epc;
    logic [2:0]  pc_sel;
    logic        exl, flush;
    int          checks = 0, errors = 0;

    typedef struct packed {
        logic [2:0]  sel;
        logic        fl;
        logic [31:0] npc;
        logic [31:0] nepc;
        logic        nexl;
    } exp_t;
    exp_t q[$];
    exp_t pend;
    bit   pend_v = 0;

    pc_seq_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .j_valid(j_valid), .j_target(j_target),
        .jr_valid(jr_valid), .jr_target(jr_target),
        .exc_req(exc_req), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret(eret),
        .pc(pc), .pc_sel(pc_sel), .epc(epc), .exl(exl), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pend_v) begin
            chk("pc", pc, pend.npc);
            chk("epc", epc, pend.nepc);
            chk("exl", {31'd0, exl}, {31'd0, pend.nexl});
            pend_v = 0;
        end
        if (q.size() > 0) begin
            pend = q.pop_front();
            chk("pc_sel", {29'd0, pc_sel}, {29'd0, pend.sel});
            chk("flush", {31'd0, flush}, {31'd0, pend.fl});
            pend_v = 1;
        end
    end

    task automatic idle_inputs();
        reset = 0; stall = 0; br_taken = 0; j_valid = 0; jr_valid = 0;
        exc_req = 0; exc_bd = 0; eret = 0;
        br_target = 0; j_target = 0; jr_target = 0; exc_pc = 0;
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic expect_(input logic [2:0] s, input logic f, input logic [31:0] npc,
                           input logic [31:0] nepc, input logic nexl);
        q.push_back('{sel: s, fl: f, npc: npc, nepc: nepc, nexl: nexl});
    endtask

    initial begin
        idle_inputs();
        start(); reset = 1;                         expect_(3'b000, 0, 32'h3000, 0, 0);
        start();                                    expect_(3'b000, 0, 32'h3004, 0, 0);
        start();                                    expect_(3'b000, 0, 32'h3008, 0, 0);
        start();                                    expect_(3'b000, 0, 32'h300C, 0, 0);
        start();                                    expect_(3'b000, 0, 32'h3010, 0, 0);
        start(); stall = 1; br_taken = 1; jr_valid = 1; br_target = 32'h3100; jr_target = 32'h3200;
                                                    expect_(3'b111, 0, 32'h3010, 0, 0);
        start(); br_taken = 1; jr_valid = 1; br_target = 32'h3100; jr_target = 32'h3200;
                                                    expect_(3'b011, 0, 32'h3200, 0, 0);
        start(); j_valid = 1; j_target = 32'h3300; br_taken = 1; br_target = 32'h3100;
                                                    expect_(3'b010, 0, 32'h3300, 0, 0);
        start(); exc_req = 1; exc_pc = 32'h3024; exc_bd = 1; stall = 1;
                                                    expect_(3'b101, 1, 32'h4180, 32'h3020, 1);
        start(); exc_req = 1; exc_pc = 32'h5000;    expect_(3'b000, 0, 32'h4184, 32'h3020, 1);
        start(); stall = 1;                         expect_(3'b111, 0, 32'h4184, 32'h3020, 1);
        start(); eret = 1;                          expect_(3'b100, 1, 32'h3020, 32'h3020, 0);
        start(); j_valid = 1; j_target = 32'h3040;  expect_(3'b010, 0, 32'h3040, 32'h3020, 0);
        start(); eret = 1;                          expect_(3'b000, 0, 32'h3044, 32'h3020, 0);
        start(); br_taken = 1; br_target = 32'hFFFF_FFFC;
                                                    expect_(3'b001, 0, 32'hFFFF_FFFC, 32'h3020, 0);
        start();                                    expect_(3'b000, 0, 32'h0000_0000, 32'h3020, 0);
        start(); exc_req = 1; exc_pc = 32'h1237;    expect_(3'b101, 1, 32'h4180, 32'h1234, 1);
        start(); eret = 1; stall = 1;               expect_(3'b100, 1, 32'h1234, 32'h1234, 0);
        start(); exc_req = 1; exc_pc = 32'h0; exc_bd = 1;
                                                    expect_(3'b101, 1, 32'h4180, 32'hFFFF_FFFC, 1);
        start(); reset = 1; eret = 1;               expect_(3'b000, 0, 32'h3000, 0, 0);
        start();                                    expect_(3'b000, 0, 32'h3004, 0, 0);
        start(); jr_valid = 1; jr_target = 32'h3ABC; expect_(3'b011, 0, 32'h3ABC, 0, 0);
        start();
        for (int i = 0; i < 10 && (q.size() > 0 || pend_v); i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0 || pend_v) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size() + int'(pend_v));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
